// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order writeback stream and the MDU result channel share one port.
// Pipeline has priority; a colliding MDU result is parked, drained when the port frees up or forced after starvation.
//
// Ports:
//   clk, rst (async, active-low)
//   pipe_we/pipe_rd/pipe_wdata : MEM/WB writeback request
//   mdu_valid/mdu_rd/mdu_wdata : MDU result, accepted when mdu_ready
//   mdu_ready                  : arbiter idle, no result parked
//   stall_pipe                 : one-cycle pipeline freeze to drain a starved result
//   rf_we/rf_waddr/rf_wdata    : registered register-file write port
//   drop_pulse                 : parked/incoming MDU result discarded (WAW)
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              drop_pulse
);

    // wait_cnt only has to reach STARVE_LIMIT-1
    localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              drop_q, drop_d;

    logic pw;
    logic mdu_acc;
    logic mdu_live;

    // Writes to x0 never occupy the port
    assign pw       = pipe_we && (pipe_rd != '0);
    assign mdu_ready = rst && (state_q == S_IDLE);
    assign mdu_acc  = mdu_valid && mdu_ready;
    assign mdu_live = mdu_acc && (mdu_rd != '0);
    assign stall_pipe = rst && (state_q == S_FORCE);

    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        drop_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pw) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = pipe_rd;
                    rf_wdata_d = pipe_wdata;
                    if (mdu_live) begin
                        if (mdu_rd == pipe_rd) begin
                            // Younger pipeline write supersedes the MDU result
                            drop_d = 1'b1;
                        end else begin
                            buf_rd_d   = mdu_rd;
                            buf_data_d = mdu_wdata;
                            wait_cnt_d = '0;
                            state_d    = S_PEND;
                        end
                    end
                end else if (mdu_live) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = mdu_rd;
                    rf_wdata_d = mdu_wdata;
                end
            end

            S_PEND: begin
                if (!pw) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = buf_rd_q;
                    rf_wdata_d = buf_data_q;
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = pipe_rd;
                    rf_wdata_d = pipe_wdata;
                    if (pipe_rd == buf_rd_q) begin
                        drop_d     = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else if (wait_cnt_q == CNT_MAX) begin
                        state_d = S_FORCE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            S_FORCE: begin
                // Pipeline is frozen; its request is re-presented next cycle
                rf_we_d    = 1'b1;
                rf_waddr_d = buf_rd_q;
                rf_wdata_d = buf_data_q;
                wait_cnt_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                wait_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            drop_q     <= drop_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign drop_pulse = drop_q;

endmodule
